// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encodings, FSM states and data width for the memory access unit.
package mem_pkg;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [2:0] {IDLE, LD, LDW, ST, RMW_RD, RMW_WT, RMW_WR, ERR} state_e;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_ILL || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/byte_lane.sv
// byte_lane: little-endian lane extraction with sign/zero extension and store-lane merging.
module byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ext,
    output logic [DATA_W-1:0] merged
);
    logic [4:0]        sh;
    logic [15:0]       lane;
    logic [DATA_W-1:0] mask;
    assign sh     = {off, 3'b000};
    assign lane   = 16'(word >> sh);
    assign mask   = size == SZ_BYTE ? 32'h0000_00FF << sh : size == SZ_HALF ? 32'h0000_FFFF << sh : '1;
    assign ext    = size == SZ_BYTE ? {{24{sgn & lane[7]}}, lane[7:0]}
                  : size == SZ_HALF ? {{16{sgn & lane[15]}}, lane[15:0]} : word;
    assign merged = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/memaccess_unit.sv
// memaccess_unit: CPU load/store front end to a single-port synchronous data memory,
// with sub-word stores done as read-modify-write.
module memaccess_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqSigned,
    input  logic [31:0]       reqAddr,
    input  logic [DATA_W-1:0] reqWdata,
    output logic              rspValid,
    output logic              rspErr,
    output logic [DATA_W-1:0] rspData,
    output logic [ADDR_W-1:0] ramAdress,
    output logic [DATA_W-1:0] ramIn,
    output logic              ramWP,
    input  logic [DATA_W-1:0] ramOut
);
    state_e            state;
    logic [1:0]        sz;
    logic              sgn;
    logic [1:0]        off;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] merged;
    logic              bad;

    assign reqReady = state == IDLE;
    assign bad      = misaligned(reqSize, reqAddr[1:0]) || |(reqAddr >> (ADDR_W + 2));

    byte_lane u_lane (
        .size  (sz),
        .sgn   (sgn),
        .off   (off),
        .word  (ramOut),
        .wdata (wdata),
        .ext   (ext),
        .merged(merged)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            ramWP     <= 1'b1;
            ramAdress <= '0;
            ramIn     <= '0;
            rspValid  <= 1'b0;
            rspErr    <= 1'b0;
            rspData   <= '0;
            sz        <= SZ_BYTE;
            sgn       <= 1'b0;
            off       <= 2'b00;
            wdata     <= '0;
        end else begin
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            case (state)
                IDLE: if (reqValid) begin
                    sz    <= reqSize;
                    sgn   <= reqSigned;
                    off   <= reqAddr[1:0];
                    wdata <= reqWdata;
                    if (bad) state <= ERR;
                    else begin
                        ramAdress <= reqAddr[ADDR_W+1:2];
                        if (!reqWrite) state <= LD;
                        else if (reqSize == SZ_WORD) begin
                            state <= ST;
                            ramIn <= reqWdata;
                            ramWP <= 1'b0;
                        end else state <= RMW_RD;
                    end
                end
                LD:     state <= LDW;
                LDW: begin
                    rspData  <= ext;
                    rspValid <= 1'b1;
                    state    <= IDLE;
                end
                ST: begin
                    ramWP    <= 1'b1;
                    rspValid <= 1'b1;
                    state    <= IDLE;
                end
                RMW_RD: state <= RMW_WT;
                // ramOut now holds the old word; the write goes out on the following edge
                RMW_WT: begin
                    ramIn <= merged;
                    ramWP <= 1'b0;
                    state <= RMW_WR;
                end
                RMW_WR: begin
                    ramWP    <= 1'b1;
                    rspValid <= 1'b1;
                    state    <= IDLE;
                end
                ERR: begin
                    rspValid <= 1'b1;
                    rspErr   <= 1'b1;
                    rspData  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memaccess_unit.sv
// tb_memaccess_unit: scoreboard bench with a behavioural synchronous RAM behind the unit.
module tb_memaccess_unit;
    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic        reqSigned = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic        rspValid;
    logic        rspErr;
    logic [31:0] rspData;
    logic [9:0]  ramAdress;
    logic [31:0] ramIn;
    logic        ramWP;
    logic [31:0] ramOut;

    memaccess_unit #(.ADDR_W(10)) dut (
        .clock(clock), .resetN(resetN), .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
        .reqWdata(reqWdata), .rspValid(rspValid), .rspErr(rspErr), .rspData(rspData),
        .ramAdress(ramAdress), .ramIn(ramIn), .ramWP(ramWP), .ramOut(ramOut)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    logic [9:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    int          cyc = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!ramWP) begin
            mem[ramAdress] <= ramIn;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= ramAdress;
            last_wd <= ramIn;
        end else ramOut <= mem[ramAdress];
    end

    logic        rsp_err  [64];
    logic [31:0] rsp_data [64];
    int          rsp_cyc  [64];
    int          rsp_n = 0;

    always @(negedge clock) begin
        if (resetN && rspValid && rsp_n < 64) begin
            rsp_err[rsp_n]  <= rspErr;
            rsp_data[rsp_n] <= rspData;
            rsp_cyc[rsp_n]  <= cyc;
            rsp_n <= rsp_n + 1;
        end
    end

    typedef struct {
        logic        err;
        logic        ld;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   rd = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic acc_rv = 1'b0;
    int   w0 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic err, input logic [31:0] d, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clock);
        while (!reqReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!reqReady) chk("accept_timeout", 32'd0, 32'd1);
        reqWrite  = w;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = a;
        reqWdata  = wd;
        reqValid  = 1'b1;
        acc_rv    = rspValid;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        if (push) begin
            e.err  = err;
            e.ld   = !w;
            e.data = d;
            e.lat  = err ? 1 : !w ? 2 : sz == 2'b10 ? 1 : 3;
            e.acc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int   n;
        exp_t e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (rsp_n <= rd && n < 50) begin
                @(negedge clock);
                #1;
                n++;
            end
            if (rsp_n <= rd) chk("rsp_timeout", 32'd0, 32'd1);
            else begin
                chk("rsp_err", 32'(rsp_err[rd]), 32'(e.err));
                if (e.ld || e.err) chk("rsp_data", rsp_data[rd], e.data);
                chk("rsp_lat", 32'(rsp_cyc[rd] - e.acc), 32'(e.lat));
                rd++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 resetN = 1'b0;
        #1;
        chk("rst_ramWP", 32'(ramWP), 32'd1);
        chk("rst_ramAdress", 32'(ramAdress), 32'd0);
        chk("rst_ramIn", ramIn, 32'd0);
        chk("rst_rspValid", 32'(rspValid), 32'd0);
        chk("rst_rspErr", 32'(rspErr), 32'd0);
        chk("rst_rspData", rspData, 32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        #1 chk("rst_reqReady", 32'(reqReady), 32'd1);

        // word store then load
        w0 = wr_cnt;
        issue(1, 2'b10, 0, 32'h10, 32'hA000_0000, 0, 0, 1);
        issue(0, 2'b10, 0, 32'h10, 0, 0, 32'hA000_0000, 1);
        drain();
        chk("st_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        chk("st_wa", 32'(last_wa), 32'd4);
        chk("st_wd", last_wd, 32'hA000_0000);

        // byte read-modify-write and sub-word loads
        issue(1, 2'b10, 0, 32'h14, 32'h5000_0000, 0, 0, 1);
        issue(1, 2'b00, 0, 32'h16, 32'h0000_00CC, 0, 0, 1);
        drain();
        chk("rmw_wa", 32'(last_wa), 32'd5);
        chk("rmw_wd", last_wd, 32'h50CC_0000);
        issue(0, 2'b00, 1, 32'h16, 0, 0, 32'hFFFF_FFCC, 1);
        issue(0, 2'b00, 0, 32'h16, 0, 0, 32'h0000_00CC, 1);
        issue(0, 2'b00, 1, 32'h17, 0, 0, 32'h0000_0050, 1);
        issue(0, 2'b10, 1, 32'h14, 0, 0, 32'h50CC_0000, 1);
        drain();

        // halfword lanes and misalignment errors
        issue(1, 2'b10, 0, 32'h18, 32'hF000_0000, 0, 0, 1);
        issue(0, 2'b01, 1, 32'h1A, 0, 0, 32'hFFFF_F000, 1);
        issue(0, 2'b01, 0, 32'h1A, 0, 0, 32'h0000_F000, 1);
        drain();
        w0 = wr_cnt;
        issue(1, 2'b01, 0, 32'h19, 32'h0000_1234, 1, 0, 1);
        issue(1, 2'b10, 0, 32'h12, 32'h1111_1111, 1, 0, 1);
        issue(0, 2'b11, 0, 32'h10, 0, 1, 0, 1);
        issue(0, 2'b10, 0, 32'h0000_1000, 0, 1, 0, 1);
        drain();
        chk("err_no_wr", 32'(wr_cnt - w0), 32'd0);
        issue(1, 2'b01, 0, 32'h1A, 32'h0000_1234, 0, 0, 1);
        issue(0, 2'b10, 0, 32'h18, 0, 0, 32'h1234_0000, 1);
        drain();

        // reset during RMW_WT aborts the store
        issue(1, 2'b10, 0, 32'h1C, 32'h7000_0000, 0, 0, 1);
        drain();
        w0 = wr_cnt;
        issue(1, 2'b00, 0, 32'h1D, 32'h0000_00CC, 0, 0, 0);
        @(posedge clock);
        #1 resetN = 1'b0;
        #1;
        chk("abort_ramWP", 32'(ramWP), 32'd1);
        chk("abort_rspValid", 32'(rspValid), 32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        chk("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
        chk("abort_no_rsp", 32'(rsp_n), 32'(rd));
        issue(0, 2'b10, 0, 32'h1C, 0, 0, 32'h7000_0000, 1);
        drain();

        // back-to-back: load accepted in the store's response cycle
        issue(1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 1);
        issue(0, 2'b10, 0, 32'h20, 0, 0, 32'hDEAD_BEEF, 1);
        chk("b2b_accept_in_rsp", 32'(acc_rv), 32'd1);
        drain();

        repeat (3) @(negedge clock);
        #1 chk("extra_rsp", 32'(rsp_n), 32'(rd));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/memaccess_unit.md
MEMACCESS_UNIT -- requirements
Module: memaccess_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, word-address width of the attached data memory.
REQ-002 SHALL provide port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL provide port resetN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port reqValid  input  1  CPU access request present.
REQ-005 SHALL provide port reqReady  output  1  unit accepts a request this cycle.
REQ-006 SHALL provide port reqWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port reqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL provide port reqSigned  input  1  sign-extend sub-word loads.
REQ-009 SHALL provide port reqAddr  input  32  byte address.
REQ-010 SHALL provide port reqWdata  input  32  store data, right-justified.
REQ-011 SHALL provide port rspValid  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port rspErr  output  1  completion is an error; qualified by rspValid.
REQ-013 SHALL provide port rspData  output  32  load result; qualified by rspValid and !reqWrite.
REQ-014 SHALL provide port ramAdress  output  ADDR_W  word address to data memory, registered.
REQ-015 SHALL provide port ramIn  output  32  write data to data memory, registered.
REQ-016 SHALL provide port ramWP  output  1  1 = read, 0 = write; memory writes at the rising edge where ramWP=0; registered.
REQ-017 SHALL provide port ramOut  input  32  memory read data, valid after the edge that sampled ramAdress with ramWP=1.

Function
REQ-018 SHALL use FSM states IDLE, LD, LDW, ST, RMW_RD, RMW_WT, RMW_WR, ERR.
REQ-019 SHALL assert reqReady only in IDLE; a request is accepted at an edge with reqValid and reqReady high (edge E0), latching all req fields.
REQ-020 SHALL flag an error when reqSize=11, halfword with reqAddr[0]=1, word with reqAddr[1:0]!=0, or reqAddr[31:ADDR_W+2] nonzero; error -> ERR; at E1 rspValid=1, rspErr=1, rspData=0, no memory write, return to IDLE.
REQ-021 SHALL perform loads as IDLE->LD (ramAdress=reqAddr[ADDR_W+1:2], ramWP=1)->LDW at E1->at E2 register extracted ramOut into rspData, rspValid=1, rspErr=0, ->IDLE.
REQ-022 SHALL perform word stores as IDLE->ST (ramIn=reqWdata, ramWP=0)->at E1 ramWP=1, rspValid=1, ->IDLE.
REQ-023 SHALL perform byte/halfword stores as read-modify-write: RMW_RD (ramWP=1)->RMW_WT at E1->at E2 ramIn=ramOut with selected lanes replaced, ramWP=0, ->RMW_WR->at E3 ramWP=1, rspValid=1, ->IDLE.
REQ-024 SHALL use little-endian lanes: byte offset k occupies bits 8k+7:8k; halfword at offset 2 occupies bits 31:16.
REQ-025 SHALL zero-extend sub-word loads when reqSigned=0 and sign-extend from the lane MSB when reqSigned=1; word loads ignore reqSigned.
REQ-026 SHALL hold ramWP=1 in every state except ST and RMW_WR, so ramWP=0 lasts exactly one cycle per store.
REQ-027 SHALL permit back-to-back requests: the rspValid cycle is in IDLE and may accept the next request.
REQ-028 SHALL hold rspData stable from a load response until the next response.

Reset
REQ-029 SHALL, while resetN=0, immediately force state IDLE, ramWP=1, ramAdress=0, ramIn=0, rspValid=0, rspErr=0, rspData=0; reqReady=1 once reset deasserts.
REQ-030 SHALL abort an in-flight access on reset without response; an RMW aborted before RMW_WR leaves memory unchanged.

Structure
REQ-031 SHALL place reqSize encodings, the FSM state enumeration and the 32-bit data width in shared package mem_pkg.
REQ-032 SHALL implement lane extract/merge/extension in one combinational sub-module byte_lane.

Verification
REQ-033 Word store 0x00000010 <- 0xA0000000, then word load 0x10 -> ramWP=0 one cycle at word 4; load rspData=0xA0000000 two edges after acceptance.
REQ-034 Memory word 5=0x50000000; byte store 0x16 <- 0x000000CC -> RMW writes 0x50CC0000; signed byte load 0x16 -> 0xFFFFFFCC; unsigned -> 0x000000CC.
REQ-035 Halfword load 0x1A signed with word 6=0xF0000000 -> 0xFFFFF000; halfword at 0x19 -> rspErr=1, no write.
REQ-036 Word load address 0x00001000 (ADDR_W=10) -> rspErr=1, rspData=0, ramWP stays 1.
REQ-037 resetN low during RMW_WT of byte store to word 7=0x70000000 -> no ramWP=0 pulse, no rspValid; later load returns 0x70000000.
REQ-038 Back-to-back: load issued in the rspValid cycle of a word store -> accepted that cycle, correct data two edges later.
